// File: rtl/nonce_uart_serializer.sv
`default_nettype none
// ============================================================================
// Module      : nonce_uart_serializer
// Description : Buffers fixed-width result words (e.g. golden nonces) from the
//               hashing core in a small FIFO. Each word goes to uart_tx as a
//               header byte followed by WORD_BYTES data bytes, one byte per
//               tx_start/tx_busy handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        : system clock
//   reset      : synchronous, active-low reset
//   word_in    : result word from the hashing core
//   word_valid : word_in is valid this cycle
//   word_ready : FIFO can accept a word (combinational)
//   tx_data    : byte presented to uart_tx data_in (registered)
//   tx_start   : one-cycle start pulse to uart_tx (registered)
//   tx_busy    : uart_tx busy
//   fifo_count : words held in the FIFO, excluding the word being sent
//   overflow   : sticky, a word was offered while the FIFO was full
//   ack_err    : sticky, tx_busy did not rise within ACK_TIMEOUT cycles
//   idle       : FIFO empty and serializer idle (combinational)
// ============================================================================
module nonce_uart_serializer #(
    parameter int         WORD_BYTES  = 4,
    parameter int         FIFO_DEPTH  = 4,
    parameter int         MSB_FIRST   = 1,
    parameter logic [7:0] HEADER_BYTE = 8'hA5,
    parameter int         ACK_TIMEOUT = 15
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [WORD_BYTES*8-1:0]         word_in,
    input  logic                            word_valid,
    output logic                            word_ready,
    output logic [7:0]                      tx_data,
    output logic                            tx_start,
    input  logic                            tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow,
    output logic                            ack_err,
    output logic                            idle
);

    localparam int WORD_W = WORD_BYTES * 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BCNT_W = $clog2(WORD_BYTES + 1);

    localparam logic [CNT_W-1:0]  C_DEPTH       = CNT_W'(FIFO_DEPTH);
    localparam logic [BCNT_W-1:0] C_WORD_BYTES  = BCNT_W'(WORD_BYTES);
    localparam logic [7:0]        C_ACK_TIMEOUT = 8'(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_ACK  = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Word FIFO
    // ------------------------------------------------------------------------
    logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;

    // ------------------------------------------------------------------------
    // Serializer state
    // ------------------------------------------------------------------------
    state_t            r_state;
    logic [WORD_W-1:0] r_shift;
    logic [BCNT_W-1:0] r_byte_cnt;
    logic [7:0]        r_timeout;
    logic [7:0]        r_tx_data;
    logic              r_tx_start;
    logic              r_ack_err;

    logic              w_push;
    logic              w_pop;
    logic [7:0]        w_next_byte;
    logic [WORD_W-1:0] w_shift_next;
    logic [7:0]        w_timeout_next;

    assign word_ready = (r_count != C_DEPTH);
    assign w_push     = word_valid && word_ready;
    // A word leaves the FIFO only when the serializer is free to take it.
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
    assign idle       = (r_state == S_IDLE) && (r_count == '0);

    assign w_timeout_next = r_timeout + 8'd1;

    // Byte order is fixed at elaboration: take the byte at the leading end
    // of the shift register and move the remainder toward it.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_next_byte  = r_shift[WORD_W-1 -: 8];
            assign w_shift_next = r_shift << 8;
        end else begin : g_lsb_first
            assign w_next_byte  = r_shift[7:0];
            assign w_shift_next = r_shift >> 8;
        end
    endgenerate

    // Storage array carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= word_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            // Depth is a power of two, so pointers wrap naturally.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // A word offered while full is dropped and flagged.
            if (word_valid && !word_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_timeout  <= '0;
            r_tx_data  <= 8'h00;
            r_tx_start <= 1'b0;
            r_ack_err  <= 1'b0;
        end else begin
            // tx_start is only ever high for the cycle following START.
            r_tx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // tx_busy is deliberately ignored here; a busy uart_tx
                    // is handled by the acknowledge wait that follows.
                    if (w_pop) begin
                        r_shift    <= r_mem[r_rd_ptr];
                        r_tx_data  <= HEADER_BYTE;
                        r_byte_cnt <= C_WORD_BYTES;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    r_tx_start <= 1'b1;
                    r_timeout  <= 8'd0;
                    r_state    <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (tx_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else begin
                        r_timeout <= w_timeout_next;
                        // uart_tx never acknowledged: drop the rest of the
                        // word so the link does not stall forever.
                        if (w_timeout_next == C_ACK_TIMEOUT) begin
                            r_ack_err <= 1'b1;
                            r_state   <= S_IDLE;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (r_byte_cnt == '0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_tx_data  <= w_next_byte;
                            r_shift    <= w_shift_next;
                            r_byte_cnt <= r_byte_cnt - BCNT_W'(1);
                            r_state    <= S_START;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_data    = r_tx_data;
    assign tx_start   = r_tx_start;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign ack_err    = r_ack_err;

endmodule
`default_nettype wire
